// File: rtl/step_gen_pkg.sv
// Shared encodings and rate tables for the step pulse generator.
// The hybrid profile table exists only when STEP_GEN_HYBRID_EN is defined.
package step_gen_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'b00,
        MODE_JOG    = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_HYBRID = 2'b11
    } stepMode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } runState_e;

    localparam logic [7:0] RATE_WALK = 8'd32;
    localparam logic [7:0] RATE_JOG  = 8'd64;
    localparam logic [7:0] RATE_RUN  = 8'd128;

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        satInc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Hybrid falls back to walk when the profile is not built in.
    function automatic logic [7:0] fixedRate(input stepMode_e m);
        case (m)
            MODE_JOG: fixedRate = RATE_JOG;
            MODE_RUN: fixedRate = RATE_RUN;
            default:  fixedRate = RATE_WALK;
        endcase
    endfunction

`ifdef STEP_GEN_HYBRID_EN
    localparam logic [15:0] HYB_BP_STEADY = 16'd9;
    localparam logic [15:0] HYB_BP_EASY   = 16'd73;
    localparam logic [15:0] HYB_BP_SPRINT = 16'd79;
    localparam logic [15:0] HYB_BP_END    = 16'd144;

    function automatic logic [7:0] hybridRate(input logic [15:0] sec);
        if (sec < HYB_BP_STEADY) begin
            case (sec[3:0])
                4'd0:    hybridRate = 8'd20;
                4'd1:    hybridRate = 8'd33;
                4'd2:    hybridRate = 8'd66;
                4'd3:    hybridRate = 8'd27;
                4'd4:    hybridRate = 8'd70;
                4'd5:    hybridRate = 8'd30;
                4'd6:    hybridRate = 8'd19;
                4'd7:    hybridRate = 8'd30;
                default: hybridRate = 8'd33;
            endcase
        end else if (sec < HYB_BP_EASY) begin
            hybridRate = 8'd69;
        end else if (sec < HYB_BP_SPRINT) begin
            hybridRate = 8'd34;
        end else if (sec < HYB_BP_END) begin
            hybridRate = 8'd124;
        end else begin
            hybridRate = 8'd0;
        end
    endfunction
`endif

endpackage

// File: rtl/step_sec_timer.sv
// Second counter: one-cycle secTick on the last cycle of each second and a
// saturating count of completed seconds.
module step_sec_timer
    import step_gen_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        advance,
    output logic        secTick,
    output logic [15:0] elapsedSec
);

    localparam logic [31:0] LAST = 32'(CLK_HZ - 1);

    logic [31:0] cnt;
    logic [31:0] cntNext;

    assign cntNext = (cnt == LAST) ? 32'd0 : cnt + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 32'd0;
            secTick    <= 1'b0;
            elapsedSec <= 16'd0;
        end else if (clear) begin
            cnt        <= 32'd0;
            secTick    <= 1'b0;
            elapsedSec <= 16'd0;
        end else begin
            // A tick cycle completes its second even if the run stops right after.
            if (secTick)
                elapsedSec <= satInc16(elapsedSec);
            if (advance) begin
                cnt     <= cntNext;
                secTick <= (cntNext == LAST);
            end else begin
                secTick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Step pulse generator: phase accumulator producing exactly `rate` pulses per
// second. Mode 11 follows the hybrid profile when STEP_GEN_HYBRID_EN is defined.
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        step_pulse,
    output logic        sec_tick,
    output logic [7:0]  rate,
    output logic [15:0] elapsed_sec,
    output logic        active
);

    localparam logic [31:0] HZ = 32'(CLK_HZ);

    runState_e   state;
    logic [31:0] acc;
    logic        entering;
    logic        advancing;
    logic        newSecond;
    logic [7:0]  modeRate;
    logic [7:0]  rateNew;
    logic [31:0] sum;

    assign entering  = (state == ST_IDLE) && start;
    assign advancing = (state == ST_RUN) && start;
    assign newSecond = entering || (advancing && sec_tick);

`ifdef STEP_GEN_HYBRID_EN
    logic [15:0] rateSec;
    // Rate is chosen for the second about to begin, hence the incremented count.
    assign rateSec  = entering ? 16'd0 : satInc16(elapsed_sec);
    assign modeRate = (stepMode_e'(mode) == MODE_HYBRID) ? hybridRate(rateSec)
                                                         : fixedRate(stepMode_e'(mode));
`else
    assign modeRate = fixedRate(stepMode_e'(mode));
`endif

    // Mode is sampled only when a second starts; the accumulator restarts there too.
    assign rateNew = newSecond ? modeRate : rate;
    assign sum     = (newSecond ? 32'd0 : acc) + {24'd0, rateNew};

    step_sec_timer #(.CLK_HZ(CLK_HZ)) uTimer (
        .clk        (clk),
        .reset      (reset),
        .clear      (entering),
        .advance    (advancing),
        .secTick    (sec_tick),
        .elapsedSec (elapsed_sec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            active     <= 1'b0;
            rate       <= 8'd0;
            step_pulse <= 1'b0;
            acc        <= 32'd0;
        end else if (start) begin
            state      <= ST_RUN;
            active     <= 1'b1;
            rate       <= rateNew;
            step_pulse <= (sum >= HZ);
            acc        <= (sum >= HZ) ? sum - HZ : sum;
        end else begin
            state      <= ST_IDLE;
            active     <= 1'b0;
            rate       <= 8'd0;
            step_pulse <= 1'b0;
            acc        <= 32'd0;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized bench for step_pulse_gen with a cycle-level reference model.
module tb_step_pulse_gen;

    localparam int C = 256;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        step_pulse;
    logic        sec_tick;
    logic [7:0]  rate;
    logic [15:0] elapsed_sec;
    logic        active;

    int checks = 0;
    int errors = 0;

    step_pulse_gen #(.CLK_HZ(C)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .step_pulse  (step_pulse),
        .sec_tick    (sec_tick),
        .rate        (rate),
        .elapsed_sec (elapsed_sec),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int satInc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic int refRate(input logic [1:0] m, input int s);
        int early[9] = '{20, 33, 66, 27, 70, 30, 19, 30, 33};
        case (m)
            2'd0: return 32;
            2'd1: return 64;
            2'd2: return 128;
            default: begin
`ifdef STEP_GEN_HYBRID_EN
                if (s < 9)   return early[s];
                if (s < 73)  return 69;
                if (s < 79)  return 34;
                if (s < 144) return 124;
                return 0;
`else
                return (s >= 0) ? 32 : early[0];
`endif
            end
        endcase
    endfunction

    // Model: running flag, cycle within second, completed seconds, rate of this second.
    int mRun = 0, mCyc = 0, mSec = 0, mRate = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mRun <= 0; mCyc <= 0; mSec <= 0; mRate <= 0;
        end else if (!start) begin
            if (mRun != 0 && mCyc == C - 1) mSec <= satInc(mSec);
            mRun <= 0; mRate <= 0;
        end else if (mRun == 0) begin
            mRun <= 1; mCyc <= 0; mSec <= 0; mRate <= refRate(mode, 0);
        end else if (mCyc == C - 1) begin
            mCyc <= 0; mSec <= satInc(mSec); mRate <= refRate(mode, satInc(mSec));
        end else begin
            mCyc <= mCyc + 1;
        end
    end

    // Pulse on cycle j iff floor(j*rate/C) steps up by one after cycle j.
    always @(negedge clk) begin
        int expPulse;
        expPulse = (mRun != 0 && ((mCyc + 1) * mRate) / C != (mCyc * mRate) / C) ? 1 : 0;
        chk("step_pulse", step_pulse, expPulse);
        chk("sec_tick", sec_tick, (mRun != 0 && mCyc == C - 1) ? 1 : 0);
        chk("active", active, mRun);
        chk("rate", rate, mRate);
        chk("elapsed_sec", elapsed_sec, mSec);
    end

    int cnt[3];
    int ticks[$];
    int hc[150];
    int r0, r1, pulses, on, off;
    int hSec[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 72, 73, 78, 79, 143, 144, 149};
`ifdef STEP_GEN_HYBRID_EN
    int hExp[17] = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 69, 34, 34, 124, 124, 0, 0};
    int hEndRate = 0;
`else
    int hExp[17] = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
    int hEndRate = 32;
`endif

    initial begin
        reset = 1'b1; start = 1'b1; mode = 2'b00;
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset active", active, 0);
        chk("reset step_pulse", step_pulse, 0);
        chk("reset sec_tick", sec_tick, 0);
        chk("reset rate", rate, 0);
        chk("reset elapsed", elapsed_sec, 0);

        // Jog for three seconds.
        mode = 2'b01; reset = 1'b1;
        for (int k = 0; k < 3 * C; k++) begin
            @(negedge clk);
            if (step_pulse) cnt[k / C]++;
            if (sec_tick) ticks.push_back(k);
        end
        @(negedge clk);
        chk("jog elapsed", elapsed_sec, 3);
        for (int i = 0; i < 3; i++) begin
            chk("jog pulses/s", cnt[i], 64);
            chk("jog tick cycle", (i < ticks.size()) ? ticks[i] : -1, (i + 1) * C - 1);
        end

        // Walk, switching to run mid-second.
        start = 1'b0;
        @(negedge clk);
        chk("stopped active", active, 0);
        start = 1'b1; mode = 2'b00;
        cnt = '{0, 0, 0};
        for (int k = 0; k < 2 * C; k++) begin
            @(negedge clk);
            if (k == 0) chk("restart elapsed", elapsed_sec, 0);
            if (step_pulse) cnt[k / C]++;
            if (k == C - 1) r0 = rate;
            if (k == C) r1 = rate;
            if (k == C / 2) mode = 2'b10;
        end
        chk("walk sec0 pulses", cnt[0], 32);
        chk("run sec1 pulses", cnt[1], 128);
        chk("rate at tick", r0, 32);
        chk("rate after tick", r1, 128);

        // Drop start inside second 5, idle 50 cycles, restart.
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 2'($urandom_range(0, 2));
        for (int k = 0; k <= 5 * C + 77; k++) @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (step_pulse || sec_tick) pulses++;
        end
        chk("idle pulses", pulses, 0);
        chk("idle elapsed", elapsed_sec, 5);
        chk("idle active", active, 0);
        start = 1'b1;
        @(negedge clk);
        chk("restart elapsed 0", elapsed_sec, 0);
        chk("restart active", active, 1);

        // Random runs, stops, mode flips and mid-second resets.
        for (int seg = 0; seg < 16; seg++) begin
            mode = 2'($urandom_range(0, 3));
            start = 1'b1;
            on = $urandom_range(1, 3 * C);
            for (int k = 0; k < on; k++) begin
                @(negedge clk);
                if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #3 reset = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                start = 1'b0;
                off = $urandom_range(1, 20);
                repeat (off) @(negedge clk);
            end
        end

        // Hybrid profile over 150 seconds.
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 2'b11;
        for (int k = 0; k < 150 * C; k++) begin
            @(negedge clk);
            if (step_pulse) hc[k / C]++;
        end
        chk("hybrid end rate", rate, hEndRate);
        @(negedge clk);
        chk("hybrid elapsed", elapsed_sec, 150);
        for (int i = 0; i < 17; i++) chk("hybrid pulses/s", hc[hSec[i]], hExp[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz (minimum 256).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  level; high = generate steps, low = idle.
REQ-005 SHALL have port mode  input  2  00 walk, 01 jog, 10 run, 11 hybrid.
REQ-006 SHALL have port step_pulse  output  1  one-cycle pulse per step.
REQ-007 SHALL have port sec_tick  output  1  one-cycle pulse on the last cycle of each second.
REQ-008 SHALL have port rate  output  8  steps/s in force for the current second.
REQ-009 SHALL have port elapsed_sec  output  16  whole seconds completed since start.
REQ-010 SHALL have port active  output  1  high while in RUN.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and RUN.
REQ-012 IDLE->RUN on the first clk edge with start=1; the first counted cycle is the cycle after the transition.
REQ-013 RUN->IDLE on any clk edge with start=0, with no further step_pulse or sec_tick.
REQ-014 SHALL count CLK_HZ cycles per second in RUN; sec_tick asserts on cycle CLK_HZ-1, then the counter wraps to 0.
REQ-015 SHALL generate steps with a phase accumulator: acc+=rate each RUN cycle; when acc>=CLK_HZ, subtract CLK_HZ and pulse step_pulse that cycle.
REQ-016 SHALL zero acc at every second boundary, giving exactly rate pulses per second.
REQ-017 Fixed rates: walk 32, jog 64, run 128 steps/s.
REQ-018 Hybrid profile by elapsed_sec: 0:20, 1:33, 2:66, 3:27, 4:70, 5:30, 6:19, 7:30, 8:33; 9-72:69; 73-78:34; 79-143:124; >=144:0.
REQ-019 SHALL latch mode and recompute rate only at RUN entry and at each sec_tick; mode changes mid-second take effect the next second.
REQ-020 elapsed_sec SHALL increment on sec_tick and saturate at 65535.
REQ-021 In hybrid, once elapsed_sec>=144, SHALL remain in RUN with rate=0 and no step_pulse, ticks continuing.
REQ-022 SHALL zero elapsed_sec, acc and the second counter on RUN entry, so a re-start restarts the profile.
REQ-023 While start=0, SHALL hold step_pulse=0, sec_tick=0, active=0, rate=0, and keep elapsed_sec at its last value.

Reset
REQ-024 On reset low: state IDLE, all outputs 0, acc/counters 0, asynchronously.
REQ-025 Reset mid-second SHALL discard the partial second; on release, resume only via REQ-012.

Configuration
REQ-026 Macro STEP_GEN_HYBRID_EN defined: mode 11 follows REQ-018.
REQ-027 Macro STEP_GEN_HYBRID_EN undefined: the profile table is omitted, and mode 11 behaves as walk (32 steps/s).

Structure
REQ-028 Package step_gen_pkg SHALL hold the mode encoding, fixed rate constants, FSM state type and hybrid profile breakpoints.
REQ-029 SHALL instantiate one sub-module step_sec_timer (second counter + sec_tick + elapsed_sec saturation); the accumulator and FSM stay in the top.

Verification (CLK_HZ=1000)
REQ-030 Reset low, start=1, mode=00 -> all outputs 0, active=0.
REQ-031 Release reset, start=1, mode=01, run 3 s -> exactly 64 step_pulse per second, sec_tick at cycles 999/1999/2999, elapsed_sec=3.
REQ-032 mode 00->10 at cycle 500 of second 0 -> second 0 has 32 pulses, second 1 has 128 pulses, rate changes on the cycle after sec_tick.
REQ-033 Hybrid, run 150 s -> pulse counts per second match REQ-018, seconds 144-149 have 0 pulses, rate=0.
REQ-034 start dropped at cycle 300 of second 5, raised again 50 cycles later -> no pulses while low, elapsed_sec reads 5 while idle, then restarts at 0.
REQ-035 Build without STEP_GEN_HYBRID_EN, mode=11 -> 32 pulses/s, rate=32.
